uc_mc: RTL and testbench

UC_MC -- requirements
Module: uc_mc

---
 rtl/uc_pkg.sv | 72 +++++++
 rtl/uc_decode.sv | 42 ++++
 rtl/uc_mc.sv | 202 ++++++++++++++++++++
 tb/tb_uc_mc.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the micro-coded controller: opcode constants,
// FSM state and instruction-class enums, register-file input selects and
// the 10-bit datapath control words.
package uc_pkg;

  // Exact six-bit opcodes
  localparam logic [5:0] OPC_JUMP = 6'b100110;
  localparam logic [5:0] OPC_IN   = 6'b100111;
  localparam logic [5:0] OPC_OUT  = 6'b101000;
  localparam logic [5:0] OPC_JAL  = 6'b101001;
  localparam logic [5:0] OPC_RET  = 6'b101010;
  localparam logic [5:0] OPC_PUSH = 6'b101011;
  localparam logic [5:0] OPC_POP  = 6'b101100;

  // Opcode families matched on their leading bits
  localparam logic [3:0] OPC_LOADINM_HI = 4'b1000;   // 1000xx
  localparam logic [4:0] OPC_BRANCH_HI  = 5'b10010;  // 10010x, bit 0 = BNEZ

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_IO_WAIT = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  // Classes that need sequencing beyond a plain two-cycle instruction
  typedef enum logic [2:0] {
    CLS_PLAIN = 3'd0,
    CLS_IN    = 3'd1,
    CLS_OUT   = 3'd2,
    CLS_JAL   = 3'd3,
    CLS_RET   = 3'd4,
    CLS_PUSH  = 3'd5,
    CLS_POP   = 3'd6
  } iclass_e;

  // Register-file input select. The interrupt vector shares code 3 with the
  // stack pop path; the IRQ cycle never writes the register file, so the
  // datapath reuses the select for the PC source there.
  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_IMM = 2'd1;
  localparam logic [1:0] SEL_IN  = 2'd2;
  localparam logic [1:0] SEL_POP = 2'd3;
  localparam logic [1:0] SEL_VEC = 2'd3;

  typedef struct packed {
    logic       s_inc;
    logic       we3;
    logic       wez;
    logic       we_port;
    logic       we_istack;
    logic       s_jret;
    logic       we_dstack;
    logic       s_ppop;
    logic [1:0] sel_inputs;
  } ctrl_t;

  //                                         inc we3 wez prt ist jrt dst pop sel
  localparam ctrl_t CW_NONE    = ctrl_t'(10'b0___0___0___0___0___0___0___0___00);
  localparam ctrl_t CW_SEQ     = ctrl_t'(10'b1___0___0___0___0___0___0___0___00);
  localparam ctrl_t CW_JUMP    = ctrl_t'(10'b0___0___0___0___0___0___0___0___00);
  localparam ctrl_t CW_ARITH   = ctrl_t'({8'b1_1_1_0_0_0_0_0, SEL_ALU});
  localparam ctrl_t CW_LOADINM = ctrl_t'({8'b1_1_0_0_0_0_0_0, SEL_IMM});
  localparam ctrl_t CW_IN      = ctrl_t'({8'b1_1_0_0_0_0_0_0, SEL_IN});
  localparam ctrl_t CW_OUT     = ctrl_t'({8'b1_0_0_1_0_0_0_0, SEL_ALU});
  localparam ctrl_t CW_JAL     = ctrl_t'({8'b0_0_0_0_1_0_0_0, SEL_ALU});
  localparam ctrl_t CW_RET     = ctrl_t'({8'b0_0_0_0_0_1_0_0, SEL_ALU});
  localparam ctrl_t CW_PUSH    = ctrl_t'({8'b1_0_0_0_0_0_1_0, SEL_ALU});
  localparam ctrl_t CW_POP     = ctrl_t'({8'b1_1_0_0_0_0_0_1, SEL_POP});
  localparam ctrl_t CW_IRQ     = ctrl_t'({8'b0_0_0_0_1_0_0_0, SEL_VEC});

endpackage

// File: rtl/uc_decode.sv
// Combinational instruction decoder: maps the registered opcode and the ALU
// zero flag to a datapath control word and an instruction class.
module uc_decode
  import uc_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic       z_i,
  output ctrl_t      ctrl_o,
  output iclass_e    cls_o
);

  logic branch_taken;

  // BEQZ (bit 0 = 0) jumps on z=1, BNEZ (bit 0 = 1) jumps on z=0
  assign branch_taken = op_i[0] ? ~z_i : z_i;

  // Decode opcode families first, then the exact opcodes
  always_comb begin
    // NOTE: every output gets a default before any branch so no path can infer a latch.
    ctrl_o = CW_NONE;
    cls_o  = CLS_PLAIN;
    if (!op_i[5]) begin
      ctrl_o = CW_ARITH;
    end else if (op_i[5:2] == OPC_LOADINM_HI) begin
      ctrl_o = CW_LOADINM;
    end else if (op_i[5:1] == OPC_BRANCH_HI) begin
      ctrl_o = branch_taken ? CW_JUMP : CW_SEQ;
    end else begin
      case (op_i)
        OPC_JUMP: ctrl_o = CW_JUMP;
        OPC_IN:   begin ctrl_o = CW_IN;   cls_o = CLS_IN;   end
        OPC_OUT:  begin ctrl_o = CW_OUT;  cls_o = CLS_OUT;  end
        OPC_JAL:  begin ctrl_o = CW_JAL;  cls_o = CLS_JAL;  end
        OPC_RET:  begin ctrl_o = CW_RET;  cls_o = CLS_RET;  end
        OPC_PUSH: begin ctrl_o = CW_PUSH; cls_o = CLS_PUSH; end
        OPC_POP:  begin ctrl_o = CW_POP;  cls_o = CLS_POP;  end
        default:  ctrl_o = CW_SEQ;
      endcase
    end
  end

endmodule

// File: rtl/uc_mc.sv
// Micro-coded controller: FETCH/EXEC/IO_WAIT/FAULT sequencer with
// return-stack and data-stack depth tracking and I/O handshakes.
// Optional interrupt entry (irq/irq_ack, enable flag) is built when the
// macro UC_IRQ_EN is defined.
module uc_mc
  import uc_pkg::*;
#(
  parameter int OPW          = 6,
  parameter int ALUW         = 3,
  parameter int ISTACK_DEPTH = 16,
  parameter int DSTACK_DEPTH = 16
) (
  input  logic            clk,
  input  logic            reset,
`ifdef UC_IRQ_EN
  input  logic            irq,
  output logic            irq_ack,
`endif
  input  logic [OPW-1:0]  opcode,
  input  logic            z,
  input  logic            port_ready,
  input  logic            in_valid,
  output logic            s_inc,
  output logic            we3,
  output logic            wez,
  output logic            we_port,
  output logic            we_istack,
  output logic            s_jret,
  output logic            we_dstack,
  output logic            s_ppop,
  output logic [1:0]      sel_inputs,
  output logic [ALUW-1:0] op_alu,
  output logic            ir_load,
  output logic            pc_en,
  output logic            port_valid,
  output logic            busy,
  output logic            fault
);

  localparam int ICW = $clog2(ISTACK_DEPTH + 1);
  localparam int DCW = $clog2(DSTACK_DEPTH + 1);
  localparam logic [ICW-1:0] ICNT_MAX = ICW'(ISTACK_DEPTH);
  localparam logic [DCW-1:0] DCNT_MAX = DCW'(DSTACK_DEPTH);

  state_e           state_q, state_d;
  logic [OPW-1:0]   ir_q, ir_d;
  logic [ICW-1:0]   icnt_q, icnt_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
`ifdef UC_IRQ_EN
  logic             ie_q, ie_d;
`endif

  ctrl_t   ctrl;
  ctrl_t   dec_ctrl;
  iclass_e dec_cls;

  uc_decode u_decode (
    .op_i   (ir_q[5:0]),
    .z_i    (z),
    .ctrl_o (dec_ctrl),
    .cls_o  (dec_cls)
  );

  assign {s_inc, we3, wez, we_port, we_istack, s_jret, we_dstack, s_ppop, sel_inputs} = ctrl;

  // State, IR and stack-depth registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
`ifdef UC_IRQ_EN
      ie_q    <= 1'b1;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      ir_q    <= ir_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
`ifdef UC_IRQ_EN
      ie_q    <= ie_d;
`endif
    end
  end

  // Next-state and output decode; outputs are held at 0 while reset is low
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    icnt_d     = icnt_q;
    dcnt_d     = dcnt_q;
    ctrl       = CW_NONE;
    op_alu     = '0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    port_valid = 1'b0;
    busy       = 1'b0;
    fault      = 1'b0;
`ifdef UC_IRQ_EN
    ie_d       = ie_q;
    irq_ack    = 1'b0;
`endif
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
`ifdef UC_IRQ_EN
          if (irq && ie_q && (icnt_q < ICNT_MAX)) begin
            // Interrupt entry replaces this fetch; the unfetched PC is pushed
            irq_ack = 1'b1;
            ctrl    = CW_IRQ;
            pc_en   = 1'b1;
            icnt_d  = icnt_q + ICW'(1);
            ie_d    = 1'b0;
          end else begin
`else
          begin
`endif
            ir_load = 1'b1;
            ir_d    = opcode;
            state_d = ST_EXEC;
          end
        end

        ST_EXEC: begin
          busy    = 1'b1;
          op_alu  = ir_q[ALUW+1:2];
          state_d = ST_FETCH;
          case (dec_cls)
            CLS_IN, CLS_OUT: state_d = ST_IO_WAIT;
            CLS_JAL: begin
              if (icnt_q == ICNT_MAX) begin
                state_d = ST_FAULT;
              end else begin
                ctrl   = dec_ctrl;
                pc_en  = 1'b1;
                icnt_d = icnt_q + ICW'(1);
              end
            end
            CLS_RET: begin
              if (icnt_q == '0) begin
                state_d = ST_FAULT;
              end else begin
                ctrl   = dec_ctrl;
                pc_en  = 1'b1;
                icnt_d = icnt_q - ICW'(1);
`ifdef UC_IRQ_EN
                ie_d   = 1'b1;
`endif
              end
            end
            CLS_PUSH: begin
              if (dcnt_q == DCNT_MAX) begin
                state_d = ST_FAULT;
              end else begin
                ctrl   = dec_ctrl;
                pc_en  = 1'b1;
                dcnt_d = dcnt_q + DCW'(1);
              end
            end
            CLS_POP: begin
              if (dcnt_q == '0) begin
                state_d = ST_FAULT;
              end else begin
                ctrl   = dec_ctrl;
                pc_en  = 1'b1;
                dcnt_d = dcnt_q - DCW'(1);
              end
            end
            default: begin
              ctrl  = dec_ctrl;
              pc_en = 1'b1;
            end
          endcase
        end

        ST_IO_WAIT: begin
          busy = 1'b1;
          if (dec_cls == CLS_OUT) begin
            port_valid = 1'b1;
            if (port_ready) begin
              ctrl    = dec_ctrl;
              pc_en   = 1'b1;
              state_d = ST_FETCH;
            end
          end else if (in_valid) begin
            ctrl    = dec_ctrl;
            pc_en   = 1'b1;
            state_d = ST_FETCH;
          end
        end

        default: begin
          // Stack fault is absorbing until reset
          fault = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uc_mc.sv
// Self-checking bench for uc_mc. Each instruction is expanded into a queue of
// per-cycle (stimulus, expected outputs) entries by a transaction-level model;
// one compare process checks every cycle, and literal checks pin the model.
module tb_uc_mc;

  localparam int IDEPTH = 16;
  localparam int DDEPTH = 16;

  localparam logic [5:0] JUMP = 6'b100110;
  localparam logic [5:0] BEQZ = 6'b100100;
  localparam logic [5:0] BNEZ = 6'b100101;
  localparam logic [5:0] IN   = 6'b100111;
  localparam logic [5:0] OUT  = 6'b101000;
  localparam logic [5:0] JAL  = 6'b101001;
  localparam logic [5:0] RET  = 6'b101010;
  localparam logic [5:0] PUSH = 6'b101011;
  localparam logic [5:0] POP  = 6'b101100;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       z, port_ready, in_valid;
  logic       s_inc, we3, wez, we_port, we_istack, s_jret, we_dstack, s_ppop;
  logic [1:0] sel_inputs;
  logic [2:0] op_alu;
  logic       ir_load, pc_en, port_valid, busy, fault;
`ifdef UC_IRQ_EN
  logic       irq, irq_ack;
`endif

  typedef struct packed {
    logic       s_inc, we3, wez, we_port, we_istack, s_jret, we_dstack, s_ppop;
    logic [1:0] sel;
    logic [2:0] alu;
    logic       ir_load, pc_en, port_valid, busy, fault;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic       z, rdy, vld, rst_n;
    obs_t       exp;
  } cyc_t;

  cyc_t q[$];
  obs_t obs_log[$];
  obs_t exp_cur;
  logic cmp_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: tracked stack depths and whether a fault has latched
  int m_icnt, m_dcnt;
  bit m_fault;

  uc_mc #(.OPW(6), .ALUW(3), .ISTACK_DEPTH(IDEPTH), .DSTACK_DEPTH(DDEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef UC_IRQ_EN
    .irq        (irq),
    .irq_ack    (irq_ack),
`endif
    .opcode     (opcode),
    .z          (z),
    .port_ready (port_ready),
    .in_valid   (in_valid),
    .s_inc      (s_inc),
    .we3        (we3),
    .wez        (wez),
    .we_port    (we_port),
    .we_istack  (we_istack),
    .s_jret     (s_jret),
    .we_dstack  (we_dstack),
    .s_ppop     (s_ppop),
    .sel_inputs (sel_inputs),
    .op_alu     (op_alu),
    .ir_load    (ir_load),
    .pc_en      (pc_en),
    .port_valid (port_valid),
    .busy       (busy),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    return {s_inc, we3, wez, we_port, we_istack, s_jret, we_dstack, s_ppop,
            sel_inputs, op_alu, ir_load, pc_en, port_valid, busy, fault};
  endfunction

  task automatic push(input logic [5:0] op, input logic zin, input logic rdy,
                      input logic vld, input logic rst_n, input obs_t e);
    cyc_t c;
    c.op = op; c.z = zin; c.rdy = rdy; c.vld = vld; c.rst_n = rst_n; c.exp = e;
    q.push_back(c);
  endtask

  task automatic rst_cycles(input int n);
    for (int i = 0; i < n; i++) push(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, obs_t'(0));
    m_icnt = 0; m_dcnt = 0; m_fault = 0;
  endtask

  // Expand one instruction into its expected cycles. IO handshakes stay low
  // for wait_n cycles of IO_WAIT; the opposite handshake is held high to
  // expose any mix-up between the two.
  task automatic instr(input logic [5:0] op, input logic zin, input int wait_n);
    obs_t e;
    bit   is_in, is_out;
    if (m_fault) begin
      e = '0; e.fault = 1'b1;
      push(op, zin, 1'b1, 1'b1, 1'b1, e);
      return;
    end
    e = '0; e.ir_load = 1'b1;
    push(op, ~zin, 1'b0, 1'b0, 1'b1, e);
    is_in  = (op == IN);
    is_out = (op == OUT);
    e = '0; e.busy = 1'b1; e.alu = op[4:2];
    case (op) inside
      6'b0?????: begin e.s_inc = 1; e.we3 = 1; e.wez = 1; e.sel = 2'd0; e.pc_en = 1; end
      6'b1000??: begin e.s_inc = 1; e.we3 = 1; e.sel = 2'd1; e.pc_en = 1; end
      BEQZ:      begin e.s_inc = !zin; e.pc_en = 1; end
      BNEZ:      begin e.s_inc = zin;  e.pc_en = 1; end
      JUMP:      e.pc_en = 1;
      IN, OUT:   ;
      JAL:  if (m_icnt == IDEPTH) m_fault = 1; else begin e.we_istack = 1; e.pc_en = 1; m_icnt++; end
      RET:  if (m_icnt == 0) m_fault = 1; else begin e.s_jret = 1; e.pc_en = 1; m_icnt--; end
      PUSH: if (m_dcnt == DDEPTH) m_fault = 1;
            else begin e.we_dstack = 1; e.s_inc = 1; e.pc_en = 1; m_dcnt++; end
      POP:  if (m_dcnt == 0) m_fault = 1;
            else begin e.s_ppop = 1; e.we3 = 1; e.sel = 2'd3; e.s_inc = 1; e.pc_en = 1; m_dcnt--; end
      default: begin e.s_inc = 1; e.pc_en = 1; end
    endcase
    push(op, zin, 1'b1, 1'b1, 1'b1, e);
    if (is_in || is_out) begin
      for (int i = 0; i < wait_n; i++) begin
        e = '0; e.busy = 1'b1; e.port_valid = is_out;
        push(op, zin, is_in, is_out, 1'b1, e);
      end
      e = '0; e.busy = 1; e.pc_en = 1; e.s_inc = 1;
      if (is_out) begin e.port_valid = 1; e.we_port = 1; end
      else        begin e.we3 = 1; e.sel = 2'd2; end
      push(op, zin, 1'b1, 1'b1, 1'b1, e);
    end
  endtask

  // OUT that is abandoned by reset after k cycles of IO_WAIT, with port_ready
  // rising in the same cycle reset falls
  task automatic out_abort(input int k);
    obs_t e;
    e = '0; e.ir_load = 1'b1;
    push(OUT, 1'b0, 1'b0, 1'b0, 1'b1, e);
    e = '0; e.busy = 1'b1; e.alu = OUT[4:2];
    push(OUT, 1'b0, 1'b0, 1'b0, 1'b1, e);
    for (int i = 0; i < k; i++) begin
      e = '0; e.busy = 1'b1; e.port_valid = 1'b1;
      push(OUT, 1'b0, 1'b0, 1'b0, 1'b1, e);
    end
    push(OUT, 1'b0, 1'b1, 1'b1, 1'b0, obs_t'(0));
    m_icnt = 0; m_dcnt = 0; m_fault = 0;
  endtask

  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      @(negedge clk);
      c = q.pop_front();
      reset = c.rst_n; opcode = c.op; z = c.z;
      port_ready = c.rdy; in_valid = c.vld;
      exp_cur = c.exp; cmp_en = 1'b1;
    end
    @(negedge clk);
    cmp_en = 1'b0;
  endtask

  // Single compare process: every driven cycle, outputs against the model
  always @(negedge clk) begin
    #2;
    if (cmp_en) begin
      check($sformatf("cycle%0d outputs", obs_log.size()), 32'(sample()), 32'(exp_cur));
      obs_log.push_back(sample());
    end
  end

  function automatic int count_field(input int from, input int to, input int which);
    int n = 0;
    for (int i = from; i <= to; i++) begin
      case (which)
        0: n += int'(obs_log[i].port_valid);
        1: n += int'(obs_log[i].we_port);
        2: n += int'(obs_log[i].we_istack);
        default: n += int'(obs_log[i].pc_en);
      endcase
    end
    return n;
  endfunction

  initial begin
    int   mj, mb0, mb1, mo, mjal, mp, mab, n_total;
    obs_t t;
    reset = 1'b0; opcode = '0; z = 1'b0; port_ready = 1'b0; in_valid = 1'b0;
    cmp_en = 1'b0; exp_cur = '0;
`ifdef UC_IRQ_EN
    irq = 1'b0;
`endif

    rst_cycles(2);
    mj = q.size();  instr(JUMP, 1'b0, 0);
    mb0 = q.size(); instr(BEQZ, 1'b0, 0);
    mb1 = q.size(); instr(BEQZ, 1'b1, 0);
    instr(BNEZ, 1'b0, 0);
    instr(BNEZ, 1'b1, 0);
    instr(6'b010110, 1'b0, 0);
    instr(6'b100011, 1'b1, 0);
    instr(6'b110000, 1'b0, 0);
    instr(6'b101111, 1'b0, 0);
    mo = q.size();  instr(OUT, 1'b0, 5);
    instr(OUT, 1'b1, 0);
    instr(IN, 1'b0, 2);
    instr(IN, 1'b1, 0);
    instr(JAL, 1'b0, 0); instr(JAL, 1'b0, 0);
    instr(RET, 1'b0, 0); instr(RET, 1'b0, 0);
    for (int i = 0; i < 3; i++) instr(PUSH, 1'b0, 0);
    for (int i = 0; i < 3; i++) instr(POP, 1'b0, 0);
    instr(RET, 1'b0, 0);
    instr(JUMP, 1'b0, 0); instr(6'b000000, 1'b0, 0);
    rst_cycles(1);
    mp = q.size();  instr(POP, 1'b0, 0);
    instr(JUMP, 1'b0, 0);
    rst_cycles(1);
    mjal = q.size();
    for (int i = 0; i < 17; i++) instr(JAL, 1'b0, 0);
    for (int i = 0; i < 3; i++) instr(JUMP, 1'b0, 0);
    rst_cycles(1);
    for (int i = 0; i < DDEPTH; i++) instr(PUSH, 1'b0, 0);
    for (int i = 0; i < DDEPTH; i++) instr(POP, 1'b1, 0);
    instr(POP, 1'b0, 0);
    instr(PUSH, 1'b0, 0);
    rst_cycles(1);
    mab = q.size(); out_abort(2);
    instr(JUMP, 1'b0, 0);
    n_total = q.size();

    run();

    // Literal expectations pinning the model
    check("log_length", 32'(obs_log.size()), 32'(n_total));
    check("reset_all_zero", 32'(obs_log[0]), 32'd0);
    check("jump_c1_ir_load", 32'(obs_log[mj].ir_load), 32'd1);
    check("jump_c2_s_inc", 32'(obs_log[mj+1].s_inc), 32'd0);
    check("jump_c2_pc_en", 32'(obs_log[mj+1].pc_en), 32'd1);
    t = obs_log[mj+2]; t.ir_load = 1'b0;
    check("jump_c3_quiet", 32'(t), 32'd0);
    check("beqz_z0_s_inc", 32'(obs_log[mb0+1].s_inc), 32'd1);
    check("beqz_z1_s_inc", 32'(obs_log[mb1+1].s_inc), 32'd0);
    check("out_port_valid_cycles", 32'(count_field(mo, mo+8, 0)), 32'd6);
    check("out_we_port_pulses", 32'(count_field(mo, mo+8, 1)), 32'd1);
    check("out_we_port_last", 32'(obs_log[mo+7].we_port), 32'd1);
    check("jal17_we_istack_pulses", 32'(count_field(mjal, mjal+36, 2)), 32'd16);
    check("jal17_fault", 32'(obs_log[mjal+34].fault), 32'd1);
    check("jal17_no_pc_en_after", 32'(count_field(mjal+33, mjal+36, 3)), 32'd0);
    check("pop_empty_s_ppop", 32'(obs_log[mp+1].s_ppop), 32'd0);
    check("pop_empty_fault", 32'(obs_log[mp+2].fault), 32'd1);
    check("abort_we_port", 32'(obs_log[mab+4].we_port), 32'd0);
    check("abort_all_zero", 32'(obs_log[mab+4]), 32'd0);

`ifdef UC_IRQ_EN
    reset = 1'b0; irq = 1'b1;
    @(negedge clk); reset = 1'b1; opcode = JUMP;
    #2;
    check("irq_ack_pulse", 32'({irq_ack, we_istack, pc_en, ir_load}), 32'b1110);
    @(negedge clk); #2;
    check("irq_masked_fetch", 32'({irq_ack, ir_load}), 32'b01);
    @(negedge clk); opcode = RET;
    @(negedge clk); #2;
    check("irq_masked_fetch2", 32'({irq_ack, ir_load}), 32'b01);
    @(negedge clk); #2;
    check("irq_ret_s_jret", 32'({s_jret, pc_en}), 32'b11);
    @(negedge clk); #2;
    check("irq_after_ret", 32'(irq_ack), 32'd1);
    irq = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time in case the stimulus loop ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
